// File: rtl/iic_eeprom_top.sv
// rtl/iic_eeprom_top.sv - push-button driven single-byte I2C master for a 24Cxx EEPROM
module iic_key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    sync_q;
  logic          stable_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        press_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;
endmodule

module iic_eeprom_top #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         SCL_FREQ     = 100_000,
  parameter int         DEBOUNCE_CYC = 1_000_000,
  parameter logic [6:0] DEV_ADDR     = 7'h50,
  parameter logic [7:0] WORD_ADDR    = 8'h00,
  parameter logic [7:0] WR_DATA      = 8'hA5
) (
  input  logic clk,
  input  logic rstn,
  input  logic key1_res,
  input  logic key2_res,
  inout  wire  sda,
  output logic scl
);
  localparam int QTR = CLK_FREQ / (4 * SCL_FREQ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEVW, S_ACK, S_WADDR, S_DATA,
    S_RSTART, S_DEVR, S_READ, S_MNACK, S_STOP
  } state_t;

  logic          key1_press, key2_press;
  state_t        state_q, state_d, ret_q, ret_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic [2:0]    bit_q, bit_d;
  logic          is_rd_q, is_rd_d, scl_q, scl_d, sda_oe_q, sda_oe_d, err_q, err_d;
  logic [7:0]    rx_q, rx_d, rd_data_q, rd_data_d, tx_byte;
  logic          tick, slot_end;

  iic_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1_db (
    .clk_i(clk), .rst_ni(rstn), .key_i(key1_res), .press_o(key1_press));
  iic_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key2_db (
    .clk_i(clk), .rst_ni(rstn), .key_i(key2_res), .press_o(key2_press));

  // Bit slot = 4 quarters: SCL low, low (SDA moves), high, high (SDA sampled); START is one quarter.
  assign tick     = (qcnt_q == QW'(QTR - 1));
  assign slot_end = tick && ((quarter_q == 2'd3) || (state_q == S_START));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      ret_q     <= S_IDLE;
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd7;
      is_rd_q   <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      err_q     <= 1'b0;
      rx_q      <= 8'h00;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      is_rd_q   <= is_rd_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      err_q     <= err_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    is_rd_d   = is_rd_q;
    scl_d     = scl_q;
    sda_oe_d  = sda_oe_q;
    err_d     = err_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    tx_byte   = 8'h00;

    if (state_q == S_IDLE) begin
      qcnt_d    = '0;
      quarter_d = 2'd0;
      bit_d     = 3'd7;
      scl_d     = 1'b1;
      sda_oe_d  = 1'b0;
      if (key1_press || key2_press) begin
        state_d  = S_START;
        is_rd_d  = !key1_press;
        err_d    = 1'b0;
        sda_oe_d = 1'b1;
      end
    end else if (!tick) begin
      qcnt_d = qcnt_q + QW'(1);
    end else begin
      qcnt_d    = '0;
      quarter_d = quarter_q + 2'd1;
      if (quarter_q == 2'd2) begin
        // An X or floating line must count as NACK, hence the else branch.
        if (state_q == S_ACK) begin
          if (sda == 1'b0) err_d = err_q;
          else             err_d = 1'b1;
        end
        if (state_q == S_READ) rx_d = {rx_q[6:0], sda};
      end

      if (slot_end) begin
        quarter_d = 2'd0;
        bit_d     = 3'd7;
        case (state_q)
          S_START:  state_d = S_DEVW;
          S_DEVW, S_WADDR, S_DATA, S_DEVR: begin
            if (bit_q != 3'd0) begin
              bit_d = bit_q - 3'd1;
            end else begin
              state_d = S_ACK;
              case (state_q)
                S_DEVW:  ret_d = S_WADDR;
                S_WADDR: ret_d = is_rd_q ? S_RSTART : S_DATA;
                S_DATA:  ret_d = S_STOP;
                default: ret_d = S_READ;
              endcase
            end
          end
          S_ACK:    state_d = err_q ? S_STOP : ret_q;
          S_RSTART: state_d = S_DEVR;
          S_READ: begin
            if (bit_q != 3'd0) begin
              bit_d = bit_q - 3'd1;
            end else begin
              state_d   = S_MNACK;
              rd_data_d = rx_q;
            end
          end
          S_MNACK:  state_d = S_STOP;
          default:  state_d = S_IDLE;
        endcase
      end

      case (state_d)
        S_DEVW:  tx_byte = {DEV_ADDR, 1'b0};
        S_WADDR: tx_byte = WORD_ADDR;
        S_DATA:  tx_byte = WR_DATA;
        S_DEVR:  tx_byte = {DEV_ADDR, 1'b1};
        default: tx_byte = 8'h00;
      endcase

      if (state_d == S_IDLE) begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end else begin
        case (quarter_d)
          2'd0: scl_d = 1'b0;
          2'd1: begin
            case (state_d)
              S_DEVW, S_WADDR, S_DATA, S_DEVR: sda_oe_d = ~tx_byte[bit_d];
              S_STOP:  sda_oe_d = 1'b1;
              default: sda_oe_d = 1'b0;
            endcase
          end
          2'd2: scl_d = 1'b1;
          default: begin
            if (state_d == S_RSTART)    sda_oe_d = 1'b1;
            else if (state_d == S_STOP) sda_oe_d = 1'b0;
          end
        endcase
      end
    end
  end

  assign scl = scl_q;
  assign sda = sda_oe_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_iic_eeprom_top.sv
// tb/tb_iic_eeprom_top.sv - scoreboard bench: expected bus events queued per press, compared by a bus monitor
module tb_iic_eeprom_top;
  localparam int CLK_FREQ = 4_000_000;
  localparam int SCL_FREQ = 100_000;
  localparam int QTR      = CLK_FREQ / (4 * SCL_FREQ);
  localparam int DEB      = 50;
  localparam logic [2:0] EV_START = 3'd1, EV_RSTART = 3'd2, EV_STOP = 3'd3, EV_BYTE = 3'd4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic key1_res = 1'b1;
  logic key2_res = 1'b1;
  logic scl;
  wire  sda;
  logic slv_drv = 1'b0;

  pullup (sda);
  assign sda = slv_drv ? 1'b0 : 1'bz;

  iic_eeprom_top #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ), .DEBOUNCE_CYC(DEB)) u_dut (
    .clk(clk), .rstn(rstn), .key1_res(key1_res), .key2_res(key2_res), .sda(sda), .scl(scl));

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [11:0] exp_q[$];
  int event_cnt = 0;
  int start_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int press_cyc = 0;
  int last_rise = 0;
  int scl_period = 0;
  int bits = 0;
  logic [8:0] sh = '0;
  logic scl_p = 1'b1, sda_p = 1'b1, busy = 1'b0, reading = 1'b0;
  logic ack_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [11:0] ev(input logic [2:0] t, input logic nack, input logic [7:0] d);
    return {t, nack, d};
  endfunction

  task automatic log_event(input logic [11:0] code);
    event_cnt++;
    if (exp_q.size() == 0) check("bus_unexpected", {20'h0, code}, 32'h0);
    else                   check("bus_event", {20'h0, code}, {20'h0, exp_q.pop_front()});
  endtask

  // Bus monitor plus 24Cxx slave model, both sampling on the falling clock edge.
  always @(negedge clk) begin
    logic s_c, d_c;
    cyc++;
    s_c = scl;
    d_c = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (!rstn) begin
      busy = 0; reading = 0; bits = 0; slv_drv = 0;
    end else if (s_c && scl_p && (d_c != sda_p)) begin
      if (!d_c) begin
        log_event(ev(busy ? EV_RSTART : EV_START, 1'b0, 8'h00));
        if (!busy) begin start_cnt++; start_cyc = cyc; end
        busy = 1;
      end else begin
        log_event(ev(EV_STOP, 1'b0, 8'h00));
        busy = 0;
      end
      bits = 0; reading = 0; slv_drv = 0;
    end else if (s_c && !scl_p) begin
      sh = {sh[7:0], d_c};
      bits++;
      scl_period = cyc - last_rise;
      last_rise = cyc;
      if (bits == 9) log_event(ev(EV_BYTE, sh[0], sh[8:1]));
    end else if (!s_c && scl_p) begin
      if (bits == 9) begin
        bits = 0;
        if (reading) reading = 0;
        else if (sh == {8'hA1, 1'b0}) reading = 1;
      end
      if (reading) slv_drv = (bits < 8) ? ~rd_byte[3'(7 - bits)] : 1'b0;
      else         slv_drv = (bits == 8) && ack_en;
    end
    scl_p = s_c;
    sda_p = d_c;
  end

  task automatic push_write();
    exp_q.push_back(ev(EV_START, 0, 8'h00));
    exp_q.push_back(ev(EV_BYTE, 0, 8'hA0));
    exp_q.push_back(ev(EV_BYTE, 0, 8'h00));
    exp_q.push_back(ev(EV_BYTE, 0, 8'hA5));
    exp_q.push_back(ev(EV_STOP, 0, 8'h00));
  endtask

  task automatic push_read(input logic [7:0] d);
    exp_q.push_back(ev(EV_START, 0, 8'h00));
    exp_q.push_back(ev(EV_BYTE, 0, 8'hA0));
    exp_q.push_back(ev(EV_BYTE, 0, 8'h00));
    exp_q.push_back(ev(EV_RSTART, 0, 8'h00));
    exp_q.push_back(ev(EV_BYTE, 0, 8'hA1));
    exp_q.push_back(ev(EV_BYTE, 1, d));
    exp_q.push_back(ev(EV_STOP, 0, 8'h00));
  endtask

  task automatic press(input int which);
    @(posedge clk); #1;
    if (which == 1) key1_res = 1'b0;
    else            key2_res = 1'b0;
    press_cyc = cyc;
  endtask

  task automatic wait_start(input string tag, input int s0);
    int n = 0;
    while (start_cnt == s0 && n < 2000) begin @(posedge clk); n++; end
    check(tag, 32'(start_cnt != s0), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin @(posedge clk); n++; end
    check(tag, exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (100) @(posedge clk);
    #1;
  endtask

  task automatic release_keys();
    @(posedge clk); #1;
    key1_res = 1'b1;
    key2_res = 1'b1;
    repeat (200) @(posedge clk);
    #1;
  endtask

  initial begin
    int s0, ev0, lat;
    repeat (20) @(posedge clk);
    #1;
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_rd_data", u_dut.rd_data_q, 0);
    check("rst_err", u_dut.err_q, 0);
    rstn = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("idle_no_activity", event_cnt, 0);
    check("idle_scl", scl, 1);

    key1_res = 1'b0;
    repeat (DEB / 2) @(posedge clk);
    #1;
    key1_res = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("glitch_ignored", event_cnt, 0);

    ack_en = 1'b1;
    push_write();
    s0 = start_cnt;
    press(1);
    wait_start("write_start", s0);
    lat = start_cyc - press_cyc;
    check("press_latency_in_range", 32'((lat >= DEB) && (lat <= DEB + 6)), 32'd1);
    wait_done("write_done");
    check("write_err", u_dut.err_q, 0);
    check("scl_period", scl_period, 4 * QTR);
    ev0 = event_cnt;
    repeat (300) @(posedge clk);
    #1;
    check("held_key_single_txn", event_cnt, ev0);
    release_keys();
    check("release_no_txn", event_cnt, ev0);

    rd_byte = 8'h3C;
    push_read(8'h3C);
    press(2);
    wait_done("read_done");
    check("read_data", u_dut.rd_data_q, 8'h3C);
    check("read_err", u_dut.err_q, 0);
    release_keys();

    ack_en = 1'b0;
    exp_q.push_back(ev(EV_START, 0, 8'h00));
    exp_q.push_back(ev(EV_BYTE, 1, 8'hA0));
    exp_q.push_back(ev(EV_STOP, 0, 8'h00));
    press(1);
    wait_done("nack_done");
    check("nack_err", u_dut.err_q, 1);
    release_keys();

    ack_en = 1'b1;
    rd_byte = 8'h81;
    push_read(8'h81);
    s0 = start_cnt;
    press(2);
    wait_start("fresh_read_start", s0);
    check("err_cleared_at_start", u_dut.err_q, 0);
    wait_done("fresh_read_done");
    check("fresh_read_data", u_dut.rd_data_q, 8'h81);
    release_keys();

    push_write();
    s0 = start_cnt;
    press(1);
    wait_start("busy_write_start", s0);
    key2_res = 1'b0;
    wait_done("busy_write_done");
    ev0 = event_cnt;
    repeat (300) @(posedge clk);
    #1;
    check("busy_key2_ignored", event_cnt, ev0);
    check("busy_rd_data_kept", u_dut.rd_data_q, 8'h81);
    check("busy_err", u_dut.err_q, 0);
    release_keys();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/iic_eeprom_top.md
Name: iic_eeprom_top

Overview:
- Top-level I2C master that performs single-byte transactions with a 24Cxx-style EEPROM, triggered by push-buttons.
- key1 press starts a byte write; key2 press starts a random-address byte read.
- Contains two key debouncers, a transaction sequencer and a standard-mode (100 kHz) bit engine driving open-drain SDA and SCL.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SCL_FREQ, 100_000, SCL frequency in Hz.
- DEBOUNCE_CYC, 1_000_000, stable-level cycles needed to accept a key edge (20 ms at 50 MHz).
- DEV_ADDR, 7'h50, 7-bit slave address (write byte 0xA0, read byte 0xA1).
- WORD_ADDR, 8'h00, EEPROM word address used by both transactions.
- WR_DATA, 8'hA5, data byte written on key1.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, reset. Asynchronous, active-low: asserting it immediately clears all state.
- key1_res, input, 1, write button, active low, asynchronous.
- key2_res, input, 1, read button, active low, asynchronous.
- sda, inout, 1, I2C data, open-drain: drives 0 or Z only. An external pull-up is required.
- scl, output, 1, I2C clock, driven 0 or 1.

Behaviour:
- Reset values:
  - scl=1; sda released (Z); sequencer in IDLE.
  - Both debouncers have stable level = 1, counters = 0.
  - rd_data=8'h00, err=0. rd_data and err are internal registers, probed hierarchically.
- Debounce, per key:
  - 2-FF synchroniser feeds the debouncer.
  - The counter increments while the synced level differs from the stable level and clears when they match.
  - When the counter reaches DEBOUNCE_CYC-1, the stable level is updated.
  - A 1→0 change of the stable level produces a one-cycle press pulse.
  - A key held low produces exactly one pulse; release produces none.
- Timing:
  - QTR = CLK_FREQ/(4*SCL_FREQ) = 125 clocks; each SCL bit is 4 quarters.
  - SDA changes only in the middle of SCL low.
  - SDA is sampled at the middle of SCL high.
- Bit-level conditions:
  - START: SDA 1→0 while SCL high, SCL low one quarter later.
  - Repeated START: SDA released, SCL raised, then SDA 0 while SCL high.
  - STOP: SDA 0, SCL raised, then SDA released while SCL high.
  - Bytes are sent MSB first; the 9th clock is ACK.
- Write transaction (key1 press in IDLE), sequencer states IDLE→START→DEVW→ACK→WADDR→ACK→DATA→ACK→STOP→IDLE. Bytes on the bus: 0xA0, WORD_ADDR, WR_DATA.
- Read transaction (key2 press in IDLE), sequencer states IDLE→START→DEVW→ACK→WADDR→ACK→RSTART→DEVR→ACK→READ→MNACK→STOP→IDLE.
  - During READ the master releases SDA for 8 clocks and shifts in MSB first.
  - The master then sends NACK (SDA released) on the 9th clock.
  - rd_data is updated at the end of READ.
- ACK check:
  - The sampled SDA must be 0.
  - Any other value (1, Z, X) is a NACK: set err=1, skip to STOP, return to IDLE.
  - err clears at the start of the next transaction.
- Key pulses arriving while not IDLE are ignored. If both keys pulse in the same cycle in IDLE, key1 (write) wins.
- Reset mid-transaction: immediate return to the reset state. Bus release is not guaranteed to be protocol-clean.
- Idle bus: scl=1, sda=Z.
- First START begins 1 to 2 clocks after the press pulse.

Test Plan:
- Reset: rstn=0 for 200 ns → scl=1, sda=Z, no bus activity for 40 ms with both keys high.
- Debounce: key1_res=0 glitch for 10 ms then 1 → no transaction. key1_res=0 held → single START ≈20 ms (1,000,000 clk) later; no second transaction while it stays low.
- Write with ACKing slave model (pull-up, ACK on every 9th clock) → bus sequence START, 0xA0+ACK, 0x00+ACK, 0xA5+ACK, STOP. SCL period 10 µs; err=0.
- Read with slave returning 0x3C → START, 0xA0, 0x00, Sr, 0xA1, data 0x3C, master NACK, STOP; rd_data=8'h3C.
- No slave (pull-up only) on key1 → START, 0xA0, NACK, STOP after 9th clock; err=1; next key2 press starts a fresh transaction with err cleared.
- key2 pressed during an active write → ignored, write completes unchanged, no read follows.
